// File: rtl/bp_pkg.sv
// Shared constants and counter encodings for the branch predictor.
package bp_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [6:0]      SB_OPCODE = 7'b1100011;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic for the predictor update path.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            SNT: o_ctr = i_taken ? WNT : SNT;
            WNT: o_ctr = i_taken ? WT  : SNT;
            WT:  o_ctr = i_taken ? ST  : WNT;
            ST:  o_ctr = i_taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged BTB; registered lookup,
// combinational mispredict/redirect. Define BP_STATS_EN for statistics outputs.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    output logic            p_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            u_valid,
    input  logic            u_is_branch,
    input  logic [XLEN-1:0] u_pc,
    input  logic            u_taken,
    input  logic [XLEN-1:0] u_target,
    input  logic            u_pred_taken,
    input  logic [XLEN-1:0] u_pred_target,
    output logic            mispredict,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_LO  = IDX_BITS + 2;
    localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

    ctr_e                r_ctr        [ENTRIES];
    logic                r_btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
    logic [XLEN-1:0]     r_btb_target [ENTRIES];

    logic                r_p_valid;
    logic                r_pred_taken;
    logic [XLEN-1:0]     r_pred_target;

    logic [IDX_BITS-1:0] w_f_idx;
    logic [IDX_BITS-1:0] w_u_idx;
    logic [TAG_BITS-1:0] w_f_tag;
    logic [TAG_BITS-1:0] w_u_tag;
    ctr_e                w_f_ctr;
    ctr_e                w_u_ctr;
    ctr_e                w_u_ctr_next;
    logic                w_f_hit;
    logic                w_upd;
    logic                w_mispredict;
    logic                w_unused;

    assign w_f_idx = f_pc[IDX_BITS+1:2];
    assign w_u_idx = u_pc[IDX_BITS+1:2];
    assign w_f_tag = f_pc[TAG_HI:TAG_LO];
    assign w_u_tag = u_pc[TAG_HI:TAG_LO];
    assign w_f_ctr = r_ctr[w_f_idx];
    assign w_u_ctr = r_ctr[w_u_idx];

    // Predict taken only when the counter leans taken and the BTB holds a matching target.
    assign w_f_hit = ((w_f_ctr == WT) || (w_f_ctr == ST))
                     && r_btb_valid[w_f_idx]
                     && (r_btb_tag[w_f_idx] == w_f_tag);

    assign w_upd = u_valid & u_is_branch;

    assign w_mispredict = w_upd & ((u_taken != u_pred_taken)
                          | (u_taken & u_pred_taken & (u_target != u_pred_target)));

    assign w_unused = ^{f_pc, SB_OPCODE};

    bp_sat_counter u_sat_counter (
        .i_ctr   (w_u_ctr),
        .i_taken (u_taken),
        .o_ctr   (w_u_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[IDX_BITS'(i)]        <= CTR_RESET;
                r_btb_valid[IDX_BITS'(i)]  <= 1'b0;
                r_btb_tag[IDX_BITS'(i)]    <= '0;
                r_btb_target[IDX_BITS'(i)] <= '0;
            end
        end else if (w_upd) begin
            r_ctr[w_u_idx] <= w_u_ctr_next;
            if (u_taken) begin
                r_btb_valid[w_u_idx]  <= 1'b1;
                r_btb_tag[w_u_idx]    <= w_u_tag;
                r_btb_target[w_u_idx] <= u_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_valid     <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_p_valid     <= f_valid;
            r_pred_taken  <= f_valid & w_f_hit;
            r_pred_target <= (f_valid & w_f_hit) ? r_btb_target[w_f_idx] : '0;
        end
    end

    assign p_valid     = r_p_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;
    assign mispredict  = w_mispredict;
    assign redirect_pc = u_taken ? u_target : u_pc + PC_INC;

`ifdef BP_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_lookups     <= '0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (f_valid)      r_stat_lookups     <= r_stat_lookups + 32'd1;
            if (w_upd)        r_stat_branches    <= r_stat_branches + 32'd1;
            if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random
// traffic against an array-based reference model.
module tb_branch_predictor;

    localparam int unsigned IDX = 6;
    localparam int unsigned TAG = 8;
    localparam int unsigned N   = 1 << IDX;

    logic        clk;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        p_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        u_valid;
    logic        u_is_branch;
    logic [31:0] u_pc;
    logic        u_taken;
    logic [31:0] u_target;
    logic        u_pred_taken;
    logic [31:0] u_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counter value 0..3 per entry plus BTB fields.
    int          m_ctr [N];
    bit          m_v   [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    logic [31:0] m_lk, m_br, m_mp;

    branch_predictor #(.IDX_BITS(IDX), .TAG_BITS(TAG)) dut (
        .clk           (clk),
        .rst           (rst),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .p_valid       (p_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .u_valid       (u_valid),
        .u_is_branch   (u_is_branch),
        .u_pc          (u_pc),
        .u_taken       (u_taken),
        .u_target      (u_target),
        .u_pred_taken  (u_pred_taken),
        .u_pred_target (u_pred_target),
        .mispredict    (mispredict),
`ifdef BP_STATS_EN
        .stat_lookups     (stat_lookups),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / (4 * N)) % (1 << TAG);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ctr[i] = 1;
            m_v[i]   = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = '0;
        end
        m_lk = '0; m_br = '0; m_mp = '0;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check registered outputs after.
    task automatic step();
        logic        e_mis, e_pv, e_pt;
        logic [31:0] e_rd, e_tg;
        int unsigned fi, ui;
        @(negedge clk);
        e_mis = u_valid && u_is_branch && ((u_taken != u_pred_taken) ||
                (u_taken && u_pred_taken && (u_target != u_pred_target)));
        e_rd  = u_taken ? u_target : u_pc + 32'd4;
        chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        chk("redirect_pc", redirect_pc, e_rd);
        if (rst) begin
            e_pv = 0; e_pt = 0; e_tg = '0;
            model_reset();
        end else begin
            fi   = idx_of(f_pc);
            e_pv = f_valid;
            e_pt = f_valid && (m_ctr[fi] >= 2) && m_v[fi] && (m_tag[fi] == tag_of(f_pc));
            e_tg = e_pt ? m_tgt[fi] : '0;
            if (f_valid) m_lk = m_lk + 1;
            if (u_valid && u_is_branch) begin
                m_br = m_br + 1;
                ui = idx_of(u_pc);
                if (u_taken) begin
                    m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_v[ui]   = 1'b1;
                    m_tag[ui] = tag_of(u_pc);
                    m_tgt[ui] = u_target;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end
            if (e_mis) m_mp = m_mp + 1;
        end
        @(posedge clk);
        #1;
        chk("p_valid", {31'd0, p_valid}, {31'd0, e_pv});
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
        chk("pred_target", pred_target, e_tg);
`ifdef BP_STATS_EN
        chk("stat_lookups", stat_lookups, m_lk);
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
    endtask

    task automatic drv(input logic fv, input logic [31:0] fpc,
                       input logic uv, input logic ub, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg,
                       input logic upt, input logic [31:0] uptg);
        f_valid = fv; f_pc = fpc;
        u_valid = uv; u_is_branch = ub; u_pc = upc; u_taken = ut;
        u_target = utg; u_pred_taken = upt; u_pred_target = uptg;
        step();
    endtask

    task automatic lookup(input logic [31:0] pc);
        drv(1, pc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                          input logic pt, input logic [31:0] ptg);
        drv(0, 32'h0, 1, 1, pc, t, tg, pt, ptg);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p       = $urandom;
        p[1:0]  = 2'b00;
        p[7:2]  = 6'($urandom_range(0, 3));
        p[15:8] = 8'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        rst = 1'b1;
        f_valid = 0; f_pc = '0; u_valid = 0; u_is_branch = 0; u_pc = '0;
        u_taken = 0; u_target = '0; u_pred_taken = 0; u_pred_target = '0;
        model_reset();

        do_reset();
        chk("reset_p_valid", {31'd0, p_valid}, 32'd0);

        lookup(32'h100);
        chk("cold_p_valid", {31'd0, p_valid}, 32'd1);
        chk("cold_taken", {31'd0, pred_taken}, 32'd0);

        u_valid = 1; u_is_branch = 1; u_pc = 32'h100; u_taken = 1; u_target = 32'h80;
        u_pred_taken = 0; u_pred_target = 32'h0; f_valid = 0;
        #1;
        chk("train_mispredict", {31'd0, mispredict}, 32'd1);
        chk("train_redirect", redirect_pc, 32'h80);
        step();
        lookup(32'h100);
        chk("trained_taken", {31'd0, pred_taken}, 32'd1);
        chk("trained_target", pred_target, 32'h80);

        update(32'h100, 0, 32'h0, 1, 32'h80);
        update(32'h100, 0, 32'h0, 0, 32'h0);
        lookup(32'h100);
        chk("decayed_taken", {31'd0, pred_taken}, 32'd0);
        u_valid = 1; u_is_branch = 1; u_pc = 32'h100; u_taken = 0; u_pred_taken = 1;
        #1;
        chk("decay_redirect", redirect_pc, 32'h104);
        step();

        update(32'h100, 1, 32'h80, 0, 32'h0);
        update(32'h100, 1, 32'h80, 0, 32'h0);
        lookup(32'h1100);
        chk("alias_taken", {31'd0, pred_taken}, 32'd0);
        drv(0, 32'h0, 1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
        lookup(32'h100);
        chk("nonbranch_keep", {31'd0, pred_taken}, 32'd1);

        do_reset();
        drv(1, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        chk("same_edge_old", {31'd0, pred_taken}, 32'd0);
        lookup(32'h100);
        chk("same_edge_new", {31'd0, pred_taken}, 32'd1);
        update(32'h100, 1, 32'h90, 1, 32'h80);
        drv(0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);

        lookup(32'h100);
        rst = 1'b1;
        drv(1, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        rst = 1'b0;
        chk("midrst_p_valid", {31'd0, p_valid}, 32'd0);
        lookup(32'h100);
        chk("midrst_taken", {31'd0, pred_taken}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tg;
            rst           = ($urandom_range(0, 99) == 0);
            f_valid       = $urandom_range(0, 1);
            f_pc          = rand_pc();
            u_valid       = $urandom_range(0, 1);
            u_is_branch   = ($urandom_range(0, 3) != 0);
            u_pc          = rand_pc();
            u_taken       = $urandom_range(0, 1);
            tg            = {24'h0, 6'($urandom_range(0, 3)), 2'b00};
            u_target      = tg;
            u_pred_taken  = $urandom_range(0, 1);
            u_pred_target = $urandom_range(0, 1) ? tg : {24'h0, 6'($urandom_range(0, 3)), 2'b00};
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
